// File: rtl/oup_ulpi_reg_engine.sv
// oup_ulpi_reg_engine: ULPI link-side PHY register access engine.
// Runs one PHY register read or write per request, with nxt timeout and abort reporting.
// Captures PHY RX CMD bytes into a small FIFO.
module oup_ulpi_reg_engine #(
  parameter int unsigned EXT_REG_EN     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RXCMD_DEPTH    = 4
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [7:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       resp_valid_o,
  output logic [7:0] resp_data_o,
  output logic [1:0] resp_status_o,
  output logic       rxcmd_valid_o,
  output logic [7:0] rxcmd_data_o,
  input  logic       rxcmd_pop_i,
  output logic       rxcmd_ovf_o,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  input  logic       ulpi_dir_i,
  output logic       ulpi_stp_o,
  input  logic       ulpi_nxt_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PtrW = $clog2(RXCMD_DEPTH);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ExtAddr = 8'h2F;

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatAbort   = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StTxCmd, StTxExt, StTxData, StStp, StRdTurn, StRdData, StRx
  } state_e;

  state_e          state_q;
  logic            dir_q;
  logic [CntW-1:0] cnt_q;
  logic            write_q;
  logic            ext_q;
  logic [7:0]      addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      data_q;
  logic            stp_q;
  logic            resp_valid_q;
  logic [1:0]      resp_status_q;
  logic [1:0]      pend_q;
  logic [7:0]      resp_data_q;

  logic       req_fire;
  logic       req_ext;
  logic [7:0] req_cmd;
  logic       in_tx;
  logic       in_wait;
  logic       progress;
  logic       abort;
  logic       timeout;

  // FIFO state
  logic [7:0]    fifo_mem [RXCMD_DEPTH];
  logic [PtrW:0] wr_ptr_q;
  logic [PtrW:0] rd_ptr_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_q;

  // Request decode and wait-state qualifiers
  always_comb begin
    req_ext  = (EXT_REG_EN != 0) && (req_addr_i >= ExtAddr);
    req_cmd  = {(req_write_i ? 2'b10 : 2'b11), (req_ext ? ExtAddr[5:0] : req_addr_i[5:0])};
    // Turnaround cycles (dir edge seen on either side) never start a transfer
    req_ready_o = (state_q == StIdle) && !ulpi_dir_i && !dir_q;
    req_fire = req_valid_i && req_ready_o;
    in_tx    = (state_q == StTxCmd) || (state_q == StTxExt) || (state_q == StTxData);
    in_wait  = in_tx || (state_q == StRdTurn);
    // TX states advance on nxt, the read turnaround advances on dir
    progress = in_tx ? ulpi_nxt_i : ulpi_dir_i;
    abort    = in_tx && ulpi_dir_i;
    timeout  = in_wait && !abort && !progress && !ulpi_nxt_i && (cnt_q == CntLast);
  end

  // Bus and output drive
  always_comb begin
    ulpi_data_oe_o = !ulpi_dir_i && !dir_q && !rst_i;
    ulpi_data_o    = data_q;
    ulpi_stp_o     = stp_q;
    resp_valid_o   = resp_valid_q;
    resp_status_o  = resp_status_q;
    resp_data_o    = resp_data_q;
    rxcmd_valid_o  = !fifo_empty;
    rxcmd_data_o   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[PtrW-1:0]];
    rxcmd_ovf_o    = ovf_q;
  end

  // Register-access FSM with registered bus, stp and response outputs
  always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      dir_q         <= 1'b0;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      ext_q         <= 1'b0;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      data_q        <= 8'h00;
      stp_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= StatOk;
      pend_q        <= StatOk;
      resp_data_q   <= 8'h00;
    end else begin
      dir_q        <= ulpi_dir_i;
      resp_valid_q <= 1'b0;
      stp_q        <= 1'b0;
      cnt_q        <= '0;
      if (abort) begin
        // PHY took the bus mid-command: no stp, report and follow it into RX
        data_q        <= 8'h00;
        resp_valid_q  <= 1'b1;
        resp_status_q <= StatAbort;
        state_q       <= StRx;
      end else if (timeout) begin
        data_q  <= 8'h00;
        stp_q   <= 1'b1;
        pend_q  <= StatTimeout;
        state_q <= StStp;
      end else if (in_wait && !progress) begin
        if (!ulpi_nxt_i) cnt_q <= cnt_q + CntW'(1);
      end else begin
        unique case (state_q)
          StIdle: begin
            data_q <= 8'h00;
            if (ulpi_dir_i) begin
              state_q <= StRx;
            end else if (req_fire) begin
              write_q <= req_write_i;
              ext_q   <= req_ext;
              addr_q  <= req_addr_i;
              wdata_q <= req_data_i;
              data_q  <= req_cmd;
              state_q <= StTxCmd;
            end
          end
          StTxCmd: begin
            if (ext_q) begin
              data_q  <= addr_q;
              state_q <= StTxExt;
            end else if (write_q) begin
              data_q  <= wdata_q;
              state_q <= StTxData;
            end else begin
              data_q  <= 8'h00;
              state_q <= StRdTurn;
            end
          end
          StTxExt: begin
            if (write_q) begin
              data_q  <= wdata_q;
              state_q <= StTxData;
            end else begin
              data_q  <= 8'h00;
              state_q <= StRdTurn;
            end
          end
          StTxData: begin
            data_q  <= 8'h00;
            stp_q   <= 1'b1;
            pend_q  <= StatOk;
            state_q <= StStp;
          end
          StStp: begin
            resp_valid_q  <= 1'b1;
            resp_status_q <= pend_q;
            state_q       <= StIdle;
          end
          StRdTurn: begin
            state_q <= StRdData;
          end
          StRdData: begin
            resp_valid_q <= 1'b1;
            if (!ulpi_nxt_i) begin
              resp_data_q   <= ulpi_data_i;
              resp_status_q <= StatOk;
            end else begin
              // nxt with dir means a USB receive started instead of register data
              resp_status_q <= StatAbort;
            end
            state_q <= StRx;
          end
          StRx: begin
            data_q <= 8'h00;
            if (!ulpi_dir_i) state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // RX CMD push/pop qualification; a pop frees the slot a same-cycle push needs
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q == {~rd_ptr_q[PtrW], rd_ptr_q[PtrW-1:0]});
    push_req   = (state_q == StRx) && ulpi_dir_i && dir_q && !ulpi_nxt_i;
    pop        = rxcmd_pop_i && !fifo_empty;
    push       = push_req && (!fifo_full || pop);
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge ulpi_clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= ulpi_data_i;
  end

endmodule
